// File: rtl/laser_pkg.sv
// laser_pkg: shared geometry, FSM states and point type for the LASER host and engine
package laser_pkg;
  localparam int NUM_OBJ   = 40;
  localparam int RADIUS_SQ = 16;
  localparam int COORD_W   = 4;
  typedef enum logic [2:0] {IDLE, ENG_RESET, STREAM, WAIT_DONE, SCORE, REPORT} state_t;
  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;
endpackage

// File: rtl/laser_cover_chk.sv
// laser_cover_chk: tells whether a point lies inside the radius-4 circle around a centre
module laser_cover_chk
  import laser_pkg::*;
(
  input  point_t p_i,
  input  point_t c_i,
  output logic   covered_o
);
  logic [COORD_W-1:0] dx, dy;
  logic [8:0] d2;
  assign dx = (p_i.x > c_i.x) ? p_i.x - c_i.x : c_i.x - p_i.x;
  assign dy = (p_i.y > c_i.y) ? p_i.y - c_i.y : c_i.y - p_i.y;
  assign d2 = 9'(dx) * 9'(dx) + 9'(dy) * 9'(dy);
  assign covered_o = d2 <= 9'(RADIUS_SQ);
endmodule

// File: rtl/laser_host.sv
// laser_host: streams a stored pattern into the LASER engine, waits for DONE and scores the returned circles
module laser_host
  import laser_pkg::*;
#(
  parameter int NUM_OBJ = laser_pkg::NUM_OBJ,
  parameter int TIMEOUT = 200000,
  parameter int TO_W    = 18
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic       busy,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       ENG_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic       result_valid,
  output logic [5:0] score,
  output logic       timeout,
  output logic [7:0] res_c1,
  output logic [7:0] res_c2
);
  state_t state_q, state_d;
  point_t mem [NUM_OBJ];
  point_t xy_q, xy_d, c1_q, c1_d, c2_q, c2_d, rd_pt;
  logic [5:0] idx_q, idx_d, score_q, score_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic eng_rst_q, eng_rst_d, busy_q, busy_d, rv_q, rv_d, to_q, to_d, cov1, cov2;
  // one shared read port serves both streaming and scoring; past the end it reads as zero
  assign rd_pt = (idx_q < 6'(NUM_OBJ)) ? mem[idx_q] : '0;
  laser_cover_chk u_cov1 (.p_i(rd_pt), .c_i(c1_q), .covered_o(cov1));
  laser_cover_chk u_cov2 (.p_i(rd_pt), .c_i(c2_q), .covered_o(cov2));
  // pattern memory is only writable while idle and keeps its contents across reset
  always_ff @(posedge CLK)
    if (wr_en && state_q == IDLE && wr_addr < 6'(NUM_OBJ)) mem[wr_addr] <= wr_data;
  // run sequencing: engine reset, stream, wait with timeout, score, report
  always_comb begin
    state_d   = state_q;
    xy_d      = xy_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    idx_d     = idx_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    to_d      = to_q;
    eng_rst_d = 1'b0;
    rv_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = ENG_RESET;
        eng_rst_d = 1'b1;
        busy_d    = 1'b1;
        idx_d     = '0;
        score_d   = '0;
        to_d      = 1'b0;
        c1_d      = '0;
        c2_d      = '0;
      end
      ENG_RESET: begin
        state_d = STREAM;
        xy_d    = rd_pt;
        idx_d   = idx_q + 6'd1;
      end
      STREAM: if (idx_q == 6'(NUM_OBJ)) begin
        state_d = WAIT_DONE;
        xy_d    = '0;
        cnt_d   = '0;
      end else begin
        xy_d  = rd_pt;
        idx_d = idx_q + 6'd1;
      end
      WAIT_DONE: if (DONE) begin
        state_d = SCORE;
        c1_d    = {C1Y, C1X};
        c2_d    = {C2Y, C2X};
        cnt_d   = '0;
        idx_d   = '0;
      end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
        state_d = REPORT;
        rv_d    = 1'b1;
        to_d    = 1'b1;
        score_d = '0;
        c1_d    = '0;
        c2_d    = '0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
      SCORE: begin
        score_d = score_q + 6'(cov1 | cov2);
        idx_d   = idx_q + 6'd1;
        state_d = (idx_q == 6'(NUM_OBJ - 1)) ? REPORT : SCORE;
        rv_d    = idx_q == 6'(NUM_OBJ - 1);
      end
      REPORT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any run in flight
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q   <= IDLE;
      xy_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      idx_q     <= '0;
      score_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      to_q      <= 1'b0;
      eng_rst_q <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      xy_q      <= xy_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      idx_q     <= idx_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      to_q      <= to_d;
      eng_rst_q <= eng_rst_d;
      rv_q      <= rv_d;
    end
  assign busy         = busy_q;
  assign ENG_RST      = eng_rst_q;
  assign X            = xy_q.x;
  assign Y            = xy_q.y;
  assign result_valid = rv_q;
  assign score        = score_q;
  assign timeout      = to_q;
  assign res_c1       = c1_q;
  assign res_c2       = c2_q;
endmodule

// File: doc/laser_host.md
Name: laser_host

Overview:
- Host-side driver and checker for the LASER coverage engine. It is the other end of the engine's X/Y object stream and C1/C2/DONE result interface.
- Holds one 40-object pattern loaded through a write port. On a start pulse it resets the engine, streams the objects one per cycle, and waits for DONE with a timeout.
- It captures both circle centres, then independently scores how many objects the two radius-4 circles cover. Used for on-chip self-test and for regression scoring.

Parameters:
- NUM_OBJ, 40, objects per pattern; must match the engine's object count.
- TIMEOUT, 200000, maximum cycles spent waiting for DONE.
- TO_W, 18, width of the timeout counter; 2^TO_W must exceed TIMEOUT.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run the stored pattern; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until the cycle result_valid pulses.
- wr_en  in  1  pattern memory write strobe; ignored while busy.
- wr_addr  in  6  object index 0..NUM_OBJ-1; addresses >= NUM_OBJ are ignored.
- wr_data  in  8  {y[3:0], x[3:0]} of the object.
- ENG_RST  out  1  synchronous reset driven to the engine.
- X  out  4  object x coordinate to the engine.
- Y  out  4  object y coordinate to the engine.
- C1X, C1Y, C2X, C2Y  in  4 each  engine circle centres; valid in the cycle DONE is high.
- DONE  in  1  engine completion pulse.
- result_valid  out  1  one-cycle pulse when score and centres are final.
- score  out  6  number of objects covered by C1 or C2 (0..40).
- timeout  out  1  set with result_valid when DONE never arrived.
- res_c1  out  8  captured {C1Y, C1X}.
- res_c2  out  8  captured {C2Y, C2X}.

Behaviour:
- All outputs are registered.
- Reset values: ENG_RST=0, X=Y=0, busy=0, result_valid=0, timeout=0, score=0, res_c1=res_c2=0, state=IDLE.
- Pattern memory is not reset.
- On async RST asserted mid-run, every output takes its reset value immediately and the in-flight run is abandoned.

State machine, IDLE -> ENG_RESET -> STREAM -> WAIT_DONE -> SCORE -> REPORT -> IDLE:
- IDLE: accepts memory writes (mem[wr_addr] <= wr_data). When start is sampled high, go to ENG_RESET.
- ENG_RESET: exactly 1 cycle with ENG_RST=1 and busy=1.
  - start sampled at edge T0 gives ENG_RST=1 in T1.
- STREAM: NUM_OBJ cycles, T2..T41, with {Y,X}=mem[i] for i=0..39 and ENG_RST=0.
  - After the last object, X and Y return to 0.
- WAIT_DONE: the timeout counter increments every cycle, starting from 0.
  - DONE=1: latch res_c1/res_c2 from the same-cycle inputs, clear the counter, go to SCORE.
  - Counter reaches TIMEOUT-1 with no DONE: timeout=1, score=0, res_c1=res_c2=0, go to REPORT.
  - DONE arriving in the same cycle as the final count: DONE wins.
- SCORE: NUM_OBJ cycles, one object per cycle. For each object:
  - dx = |x - cx| and dy = |y - cy|, unsigned 4-bit.
  - Covered if dx*dx + dy*dy <= 16, evaluated in 9 bits (max 450).
  - Count +1 if covered by res_c1 or res_c2; an object covered by both counts once.
  - The 6-bit counter cannot overflow (maximum 40).
- REPORT: result_valid=1 for 1 cycle, with score and timeout stable.
  - Next cycle: busy=0, state=IDLE.
  - score, timeout, res_c1 and res_c2 hold until the next run's ENG_RESET, which clears them.
- DONE seen outside WAIT_DONE is ignored.
- start while busy is dropped, not queued.
- Writes while busy are dropped.

Decomposition:
- Shared package laser_pkg:
  - constants NUM_OBJ=40, RADIUS_SQ=16, COORD_W=4;
  - state enum {IDLE, ENG_RESET, STREAM, WAIT_DONE, SCORE, REPORT};
  - packed type point_t {y, x}, COORD_W bits each.
- One sub-module, laser_cover_chk: combinational; inputs a point and a centre, output covered. Instantiated twice, once per circle.
- The engine uses the same geometry, so the package keeps host and engine consistent.

Test Plan:
- Reset → outputs: assert RST mid-STREAM (i=17) → next sample shows ENG_RST=0, X=Y=0, busy=0, result_valid=0. A fresh start then replays from mem[0].
- Full coverage: objects 0-19 at (2,2) and 20-39 at (12,12); engine model returns DONE with C1=(2,2), C2=(12,12) → score=40, timeout=0, res_c1=0x22, res_c2=0xCC.
- Partial coverage: same pattern, C2=(0,15) → score=20. An object covered by both circles counts once: all 40 objects at (5,5) with C1=C2=(5,5) → score=40.
- Radius boundary with C1=C2=(3,3):
  - objects at (7,3), (6,5), (5,6) are covered;
  - objects at (6,6), (8,3) are not;
  - remaining 35 objects at (15,15) → score=3.
- Timeout: DONE held low, TIMEOUT=100 → result_valid exactly 100 cycles after WAIT_DONE entry, with timeout=1 and score=0. A late DONE afterwards is ignored.
- Protocol timing:
  - start at T0 → ENG_RST high only in T1; {Y,X}=mem[0] in T2 and mem[39] in T41.
  - start and wr_en pulsed during WAIT_DONE → no second run, memory unchanged.
  - Back-to-back: start the cycle after result_valid → new run accepted.
